// File: rtl/v2f_sched_pkg.sv
// Shared opcode/state encodings for the v2f ALU scheduler.
package v2f_sched_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SSHR = 4'd8,
        OP_DIV  = 4'd9,
        OP_MOD  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/v2f_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module v2f_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_oh,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_grant
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any_grant && req[idx]) begin
                any_grant     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/v2f_alu_sched.sv
// Round-robin shared ALU: one op in flight, IDLE -> EXEC -> RESP.
// Define V2F_ALU_SCHED_DIV_EN to build the signed DIV/MOD datapath.
module v2f_alu_sched
    import v2f_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [OP_W*N_REQ-1:0]    req_op,
    input  logic [WIDTH*N_REQ-1:0]   req_a,
    input  logic [WIDTH*N_REQ-1:0]   req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]         resp_y,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);

    state_e state, state_nxt;

    logic [IW-1:0]    ptr, id_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic [N_REQ-1:0] grant_oh;
    logic [IW-1:0]    grant_idx;
    logic             any_grant;
    logic             accept;

    logic [OP_W-1:0]  op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[g*OP_W +: OP_W];
        assign a_arr[g]  = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g]  = req_b[g*WIDTH +: WIDTH];
    end

    v2f_rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req_ready  = '0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_grant) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Outputs read as idle while reset is held, whatever the state register says.
        if (!rst) begin
            req_ready  = accept ? grant_oh : '0;
            resp_valid = (state == ST_RESP);
            busy       = (state != ST_IDLE);
        end
    end

    logic [WIDTH-1:0]        alu_y;
    logic                    alu_err;
    logic [4:0]              shamt;
    logic signed [WIDTH-1:0] sa;

    assign shamt = b_q[4:0];
    assign sa    = $signed(a_q);

`ifdef V2F_ALU_SCHED_DIV_EN
    logic signed [WIDTH-1:0] sb;
    assign sb = $signed(b_q);
`endif

    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (op_e'(op_q))
            OP_ADD:  alu_y = a_q + b_q;
            OP_SUB:  alu_y = a_q - b_q;
            OP_MUL:  alu_y = a_q * b_q;
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            OP_XOR:  alu_y = a_q ^ b_q;
            OP_SHL:  alu_y = a_q << shamt;
            OP_SHR:  alu_y = a_q >> shamt;
            OP_SSHR: alu_y = sa >>> shamt;
`ifdef V2F_ALU_SCHED_DIV_EN
            // Divide-by-zero yields 0 without an error flag.
            OP_DIV:  if (b_q != '0) alu_y = sa / sb;
            OP_MOD:  if (b_q != '0) alu_y = sa % sb;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            id_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            resp_y   <= '0;
            resp_id  <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                id_q <= grant_idx;
                op_q <= op_arr[grant_idx];
                a_q  <= a_arr[grant_idx];
                b_q  <= b_arr[grant_idx];
                ptr  <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ST_EXEC) begin
                resp_y   <= alu_y;
                resp_err <= alu_err;
                resp_id  <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_v2f_alu_sched.sv
// Self-checking bench for v2f_alu_sched: transaction-level model plus directed literal checks.
module tb_v2f_alu_sched;
    import v2f_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_y;
    logic           resp_err;
    logic           busy;

    int tests = 0;
    int errs  = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int grant_q[$];
    int gcyc_q[$];

    v2f_alu_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // First requester at or after p (wrapping) that is asking, else -1.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Returns {err, y} from plain arithmetic on the operation's definition.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sh;
        longint sa, sb, ma, mb, q, r;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
            4'd2: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p[31:0]}; end
            4'd3: return {1'b0, a & b};
            4'd4: return {1'b0, a | b};
            4'd5: return {1'b0, a ^ b};
            4'd6: return {1'b0, a << sh};
            4'd7: return {1'b0, a >> sh};
            4'd8: return a[31] ? {1'b0, ~((~a) >> sh)} : {1'b0, a >> sh};
`ifdef V2F_ALU_SCHED_DIV_EN
            4'd9, 4'd10: begin
                if (b == 32'd0) return 33'd0;
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = ma / mb;
                r  = ma % mb;
                if (op == 4'd9) q = ((sa < 0) != (sb < 0)) ? -q : q;
                else            q = (sa < 0) ? -r : r;
                return {1'b0, q[31:0]};
            end
`endif
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Transaction model: an accepted op owes a response one cycle after EXEC.
    bit           m_inflight = 1'b0;
    int           m_age = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    logic [W-1:0] m_y = '0;
    logic         m_err = 1'b0;
    int           m_pick;

    always_comb m_pick = pick(req_valid, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_inflight <= 1'b0;
            m_age      <= 0;
            m_ptr      <= 0;
        end else if (!m_inflight) begin
            if (m_pick >= 0) begin
                m_inflight     <= 1'b1;
                m_age          <= 0;
                m_id           <= m_pick;
                {m_err, m_y}   <= ref_alu(req_op[m_pick*4 +: 4], req_a[m_pick*W +: W], req_b[m_pick*W +: W]);
                m_ptr          <= (m_pick + 1) % N;
            end
        end else if (m_age >= 1 && resp_ready) begin
            m_inflight <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    logic [N-1:0] e_rdy;
    logic         e_vld;
    logic         e_busy;

    always @(negedge clk) begin
        if (chk_en) begin
            e_rdy = '0;
            if (!rst && !m_inflight && m_pick >= 0) e_rdy[m_pick] = 1'b1;
            e_vld  = !rst && m_inflight && (m_age >= 1);
            e_busy = !rst && m_inflight;
            check("mdl_req_ready", req_ready, e_rdy);
            check("mdl_resp_valid", resp_valid, e_vld);
            check("mdl_busy", busy, e_busy);
            if (e_vld) begin
                check("mdl_resp_y", resp_y, m_y);
                check("mdl_resp_id", resp_id, m_id);
                check("mdl_resp_err", resp_err, m_err);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int k = 0; k < N; k++)
                if (req_ready[k]) begin
                    grant_q.push_back(k);
                    gcyc_q.push_back(cyc);
                end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[id*4 +: 4] = op;
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_valid[id]     = 1'b1;
    endtask

    task automatic wait_accept(input int id);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        tick();
        set_req(id, op, a, b);
        wait_accept(id);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int id, input logic [31:0] y, input logic err, input int lat);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                n  = i;
                ok = 1'b1;
                break;
            end
        end
        check({name, "_lat"}, n, lat);
        if (ok) begin
            check({name, "_y"}, resp_y, y);
            check({name, "_id"}, resp_id, id);
            check({name, "_err"}, resp_err, err);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_y", resp_y, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_busy", busy, 0);

        // Request presented while reset is held must not be acknowledged.
        tick();
        rst = 1'b1;
        req_valid = 4'b0100;
        @(negedge clk);
        check("rst_hold_ready", req_ready, 0);
        check("rst_hold_busy", busy, 0);
        tick();
        rst = 1'b0;
        req_valid = '0;

        issue(1, OP_ADD, 32'd7, 32'hFFFF_FFF6);
        wait_resp("add", 1, 32'hFFFF_FFFD, 1'b0, 2);
        issue(3, OP_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_resp("mul_wrap", 3, 32'h0, 1'b0, 2);
        issue(0, OP_SSHR, 32'h8000_0000, 32'd31);
        wait_resp("sshr31", 0, 32'hFFFF_FFFF, 1'b0, 2);
        issue(2, OP_SHR, 32'h8000_0000, 32'd31);
        wait_resp("shr31", 2, 32'h1, 1'b0, 2);
        issue(1, OP_SHL, 32'd3, 32'd33);
        wait_resp("shl33", 1, 32'd6, 1'b0, 2);
        issue(3, OP_SHL, 32'h1234, 32'd0);
        wait_resp("shl0", 3, 32'h1234, 1'b0, 2);
        issue(0, OP_AND, 32'hF0F0, 32'hFF00);
        wait_resp("and", 0, 32'hF000, 1'b0, 2);
        issue(2, OP_OR, 32'hF0F0, 32'hFF00);
        wait_resp("or", 2, 32'hFFF0, 1'b0, 2);

        // Consumer back-pressure: response must hold for 5 cycles.
        tick();
        resp_ready = 1'b0;
        issue(2, OP_SUB, 32'd5, 32'd7);
        wait_resp("stall_sub", 2, 32'hFFFF_FFFE, 1'b0, 2);
        tick();
        set_req(0, OP_XOR, 32'hF0F0, 32'hFF00);
        repeat (4) begin
            @(negedge clk);
            check("stall_valid", resp_valid, 1);
            check("stall_y", resp_y, 32'hFFFF_FFFE);
            check("stall_ready", req_ready, 0);
            check("stall_busy", busy, 1);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        check("release_valid", resp_valid, 1);
        @(negedge clk);
        check("idle_after_release", req_ready, 4'b0001);
        check("idle_after_release_busy", busy, 0);
        tick();
        req_valid = '0;
        wait_resp("xor", 0, 32'h0FF0, 1'b0, 2);

        // Saturated requesters after reset: strict rotation, one accept per 3 cycles.
        tick();
        do_reset();
        grant_q.delete();
        gcyc_q.delete();
        for (int i = 0; i < N; i++) set_req(i, OP_ADD, 32'(i), 32'd100);
        for (int i = 0; i < 40 && grant_q.size() < 5; i++) tick();
        req_valid = '0;
        check("tp_count", grant_q.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
            check("tp_order", grant_q[k], k % N);
            if (k > 0) check("tp_spacing", gcyc_q[k] - gcyc_q[k-1], 3);
        end
        repeat (4) tick();

        // Reset during EXEC drops the op and rewinds the pointer.
        set_req(1, OP_ADD, 32'd1, 32'd1);
        wait_accept(1);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_resp", resp_valid, 0);
        end
        tick();
        set_req(3, OP_XOR, 32'd5, 32'd6);
        set_req(0, OP_OR, 32'd1, 32'd2);
        @(negedge clk);
        check("rst_ptr_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp("rst_next", 0, 32'd3, 1'b0, 2);

`ifdef V2F_ALU_SCHED_DIV_EN
        issue(1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_resp("div_neg", 1, 32'hFFFF_FFFD, 1'b0, 2);
        issue(2, OP_MOD, 32'hFFFF_FFF9, 32'd2);
        wait_resp("mod_neg", 2, 32'hFFFF_FFFF, 1'b0, 2);
        issue(3, OP_DIV, 32'd5, 32'd0);
        wait_resp("div_zero", 3, 32'd0, 1'b0, 2);
`else
        issue(1, OP_DIV, 32'd5, 32'd1);
        wait_resp("div_off", 1, 32'd0, 1'b1, 2);
`endif
        issue(0, 4'd15, 32'd1, 32'd2);
        wait_resp("op15", 0, 32'd0, 1'b1, 2);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
